// File: rtl/dpc_linebuf_window.sv
// Multi-line buffer for the dead-pixel-correction datapath: emits each pixel together
// with the co-located pixels of up to LINES previous rows as one vertical tap bus.
module dpc_linebuf_window #(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = 1024,
  parameter int LINES     = 2,
  parameter int AW        = $clog2(MAX_DEPTH),
  parameter int LW        = AW + 1,
  parameter int FW        = $clog2(LINES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LW-1:0]                cfg_len,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         out_valid,
  output logic [(LINES+1)*WIDTH-1:0]   out_taps,
  output logic [AW-1:0]                out_col,
  output logic                         out_eol,
  output logic [FW-1:0]                out_fill,
  output logic                         err_len
);

  localparam logic [LW-1:0] LEN_MIN = LW'(2);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_DEPTH);
  localparam logic [FW-1:0] ROW_SAT = FW'(LINES);

  // Reset has priority, so a beat arriving while reset is asserted is not accepted.
  logic accept;
  logic sof_accept;
  assign accept     = in_valid & reset;
  assign sof_accept = accept & in_sof;

  logic [LW-1:0] cfg_len_clamped;
  logic          cfg_len_bad;

  always_comb begin
    cfg_len_clamped = cfg_len;
    cfg_len_bad     = 1'b0;
    if (cfg_len < LEN_MIN) begin
      cfg_len_clamped = LEN_MIN;
      cfg_len_bad     = 1'b1;
    end else if (cfg_len > LEN_MAX) begin
      cfg_len_clamped = LEN_MAX;
      cfg_len_bad     = 1'b1;
    end
  end

  logic [AW-1:0] col_q, col_d;
  logic [FW-1:0] row_q, row_d;
  logic [LW-1:0] len_q, len_d;
  logic          err_q, err_d;

  // Position of the pixel being accepted this cycle; an SOF restarts both counters.
  logic [AW-1:0] pix_col;
  logic [FW-1:0] pix_row;
  logic [LW-1:0] eff_len;
  logic          pix_eol;

  always_comb begin
    pix_col = in_sof ? '0 : col_q;
    pix_row = in_sof ? '0 : row_q;
    eff_len = in_sof ? cfg_len_clamped : len_q;
    pix_eol = ({1'b0, pix_col} == (eff_len - LW'(1)));
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    len_d = len_q;
    err_d = err_q;
    if (accept) begin
      col_d = pix_eol ? '0 : (pix_col + AW'(1));
      row_d = (pix_eol && (pix_row != ROW_SAT)) ? (pix_row + FW'(1)) : pix_row;
    end
    if (sof_accept) begin
      len_d = cfg_len_clamped;
      err_d = err_q | cfg_len_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      len_q <= LEN_MAX;
      err_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      len_q <= len_d;
      err_q <= err_d;
    end
  end

  logic             valid_q;
  logic [WIDTH-1:0] tap0_q;
  logic [AW-1:0]    ocol_q;
  logic             oeol_q;
  logic [FW-1:0]    fill_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      tap0_q  <= '0;
      ocol_q  <= '0;
      oeol_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      valid_q <= in_valid;
      if (accept) begin
        tap0_q <= data_in;
        ocol_q <= pix_col;
        oeol_q <= pix_eol;
        fill_q <= pix_row;
      end
    end
  end

  // Cascade into the deeper line memories one cycle after the accept, at the same column.
  logic          wr_pend_q;
  logic [AW-1:0] wr_addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_pend_q <= accept;
      wr_addr_q <= pix_col;
    end
  end

  logic [LINES*WIDTH-1:0] rd_bus;

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
      logic [WIDTH-1:0] mem [MAX_DEPTH];
      logic [WIDTH-1:0] rdata_q;
      logic             wen;
      logic [AW-1:0]    waddr;
      logic [WIDTH-1:0] wdata;

      if (gi == 0) begin : g_head
        assign wen   = accept;
        assign waddr = pix_col;
        assign wdata = data_in;
      end else begin : g_tail
        assign wen   = wr_pend_q & reset;
        assign waddr = wr_addr_q;
        assign wdata = rd_bus[(gi-1)*WIDTH +: WIDTH];
      end

      // Read-first: the read returns the row above before this row overwrites it.
      always_ff @(posedge clk) begin
        if (wen) begin
          mem[waddr] <= wdata;
        end
        if (accept) begin
          rdata_q <= mem[pix_col];
        end
      end

      assign rd_bus[gi*WIDTH +: WIDTH] = rdata_q;
    end
  endgenerate

  assign out_taps[0 +: WIDTH] = tap0_q;

  generate
    for (genvar gi = 1; gi <= LINES; gi++) begin : g_tap
      // Upper taps above the frame's filled rows carry stale memory contents; hide them.
      assign out_taps[gi*WIDTH +: WIDTH] =
        (FW'(gi) <= fill_q) ? rd_bus[(gi-1)*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_col   = ocol_q;
  assign out_eol   = oeol_q;
  assign out_fill  = fill_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_dpc_linebuf_window.sv
// Randomised bench for dpc_linebuf_window: a frame-position reference model predicts
// every output beat, plus a few literal expectations pinned to fixed stimulus.
module tb_dpc_linebuf_window;

  localparam int W  = 16;
  localparam int MD = 1024;
  localparam int L  = 4;
  localparam int AW = $clog2(MD);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(L + 1);
  localparam int TW = (L + 1) * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          out_valid;
  logic [TW-1:0] out_taps;
  logic [AW-1:0] out_col;
  logic          out_eol;
  logic [FW-1:0] out_fill;
  logic          err_len;

  dpc_linebuf_window #(.WIDTH(W), .MAX_DEPTH(MD), .LINES(L)) dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len), .in_valid(in_valid), .in_sof(in_sof),
    .data_in(data_in), .out_valid(out_valid), .out_taps(out_taps), .out_col(out_col),
    .out_eol(out_eol), .out_fill(out_fill), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int n_ov = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a pixel's place in the frame is its accept index within the frame,
  // split into row and column by the latched line length.
  int            m_pos = 0;
  int            m_len = MD;
  logic          m_err = 1'b0;
  logic [W-1:0]  frame [int];
  logic          exp_valid = 1'b0;
  logic [TW-1:0] exp_taps = '0;
  int            exp_col = 0;
  logic          exp_eol = 1'b0;
  int            exp_fill = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_pos = 0; m_len = MD; m_err = 1'b0; frame.delete();
        exp_valid = 1'b0; exp_taps = '0; exp_col = 0; exp_eol = 1'b0; exp_fill = 0;
      end else if (in_valid) begin
        int c, r;
        if (in_sof) begin
          if (int'(cfg_len) < 2) begin m_len = 2; m_err = 1'b1; end
          else if (int'(cfg_len) > MD) begin m_len = MD; m_err = 1'b1; end
          else m_len = int'(cfg_len);
          m_pos = 0;
          frame.delete();
        end
        c = m_pos % m_len;
        r = m_pos / m_len;
        frame[r*4096 + c] = data_in;
        exp_valid = 1'b1;
        exp_col = c;
        exp_eol = (c == m_len - 1);
        exp_fill = (r < L) ? r : L;
        exp_taps = '0;
        exp_taps[0 +: W] = data_in;
        for (int k = 1; k <= L; k++) begin
          if (k <= exp_fill && frame.exists((r-k)*4096 + c))
            exp_taps[k*W +: W] = frame[(r-k)*4096 + c];
        end
        m_pos++;
      end else begin
        exp_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) n_ov++;
      chk("out_valid", out_valid, exp_valid);
      chk("err_len", err_len, m_err);
      if (exp_valid) begin
        chk("out_col", out_col, exp_col);
        chk("out_eol", out_eol, exp_eol);
        chk("out_fill", out_fill, exp_fill);
        chk("out_taps", out_taps, exp_taps);
      end
    end
  end

  task automatic beat(input logic sof, input logic [LW-1:0] len, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_sof = sof; cfg_len = len; data_in = d;
    if (reset) n_acc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_sof = 1'($urandom_range(0, 1));
      cfg_len = LW'($urandom); data_in = W'($urandom);
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    settle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_taps", out_taps, '0);
    chk("rst_col_fill_eol_err", {out_col, out_fill, out_eol, err_len}, '0);
    @(negedge clk); reset = 1'b1;

    // Continuous frame, len 8, pixel = row*16+col
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        beat(r == 0 && c == 0, LW'(8), W'(r*16 + c));
        if (r == 0 && c == 3) begin
          settle();
          chk("lit_row0_fill", out_fill, 0);
          chk("lit_row0_upper", out_taps >> W, '0);
        end
        if (r == 2 && c == 5) begin
          settle();
          chk("lit_r2c5_taps", out_taps, 80'h0000_0000_0005_0015_0025);
          chk("lit_r2c5_fill", out_fill, 2);
        end
        if (r == 1 && c >= 6) begin
          settle();
          chk("lit_eol", out_eol, c == 7);
        end
      end
    end
    idle(3);

    // Same frame with random gaps
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        beat(r == 0 && c == 0, LW'(8), W'(r*16 + c));
        idle($urandom_range(0, 5));
      end

    // Length clamping: 1 -> 2, then 2000 -> MAX_DEPTH
    beat(1'b1, LW'(1), 16'h0100);
    for (int i = 1; i < 6; i++) beat(1'b0, LW'(7), W'(16'h0100 + i));
    settle();
    chk("lit_err_after_low", err_len, 1'b1);
    beat(1'b1, LW'(2000), 16'h0200);
    for (int i = 1; i < 1030; i++) beat(1'b0, LW'(5), W'(i));
    settle();
    chk("lit_err_sticky", err_len, 1'b1);
    idle(2);

    // SOF in mid-line truncates row 3
    for (int i = 0; i < 28; i++) beat(i == 0, LW'(8), W'(16'h3000 + i));
    beat(1'b1, LW'(8), 16'h0abc);
    settle();
    chk("lit_trunc_col", out_col, 0);
    chk("lit_trunc_fill", out_fill, 0);
    chk("lit_trunc_taps", out_taps, 80'h0abc);
    for (int i = 0; i < 3; i++) beat(1'b0, LW'(8), W'(i));

    // One-cycle reset in mid-line, resume without SOF
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_sof = 1'b0; data_in = 16'hdead;
    settle();
    chk("lit_mrst_valid", out_valid, 1'b0);
    chk("lit_mrst_taps", out_taps, '0);
    chk("lit_mrst_misc", {out_col, out_fill, out_eol, err_len}, '0);
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    beat(1'b0, LW'(3), 16'h0042);
    settle();
    chk("lit_resume_col", out_col, 0);
    chk("lit_resume_fill", out_fill, 0);
    for (int i = 1; i < 1027; i++) beat(1'b0, LW'(3), W'($urandom));
    idle(2);

    // Minimum length over 6 rows with all four delayed lines
    for (int i = 0; i < 12; i++) beat(i == 0, LW'(2), W'($urandom));
    idle(1);
    for (int i = 0; i < 12; i++) begin
      beat(i == 0, LW'(2), W'($urandom));
      idle($urandom_range(0, 2));
    end

    // Random frames, lengths, SOF positions and gaps
    for (int i = 0; i < 600; i++) begin
      logic [LW-1:0] l;
      case ($urandom_range(0, 9))
        0: l = LW'($urandom_range(0, 1));
        1: l = LW'($urandom_range(1025, 2047));
        default: l = LW'($urandom_range(2, 12));
      endcase
      beat(($urandom_range(0, 39) == 0) || i == 0, l, W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(4);

    chk("out_valid_count", n_ov, n_acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
